// File: rtl/spectrum_integration_ctrl_if.sv
// Interface bundling the run/config inputs, the FFT sample handshake and the
// accumulator control / RAM address outputs of spectrum_integration_ctrl.
// master = FFT/config side (drives inputs), slave = the sequencer itself.
interface spectrum_integration_ctrl_if #(
   parameter int FFT_LOG2  = 12,
   parameter int NINT_W    = 10,
   parameter int NBUF_LOG2 = 4
);
   logic                 enable;
   logic [NINT_W-1:0]    num_integrations;
   logic                 peak_detect_cfg;
   logic                 in_valid;
   logic                 in_last;
   logic                 acc_clken;
   logic                 acc_add;
   logic                 acc_peak;
   logic [FFT_LOG2-1:0]  rd_addr;
   logic                 wr_en;
   logic [FFT_LOG2-1:0]  wr_addr;
   logic [NBUF_LOG2-1:0] buf_idx;
   logic                 frame_done;
   logic                 misalign_err;

   modport master (
      output enable, num_integrations, peak_detect_cfg, in_valid, in_last,
      input  acc_clken, acc_add, acc_peak, rd_addr, wr_en, wr_addr,
             buf_idx, frame_done, misalign_err
   );

   modport slave (
      input  enable, num_integrations, peak_detect_cfg, in_valid, in_last,
      output acc_clken, acc_add, acc_peak, rd_addr, wr_en, wr_addr,
             buf_idx, frame_done, misalign_err
   );
endinterface

// File: rtl/spectrum_integration_ctrl.sv
// spectrum_integration_ctrl: sequencer for the complex-power accumulator.
// Counts FFT bins and integration frames, drives the accumulator enable and
// load/add/peak controls, and delays each read address by the datapath
// latency to form the RAM write-back. A marker travelling with the last bin
// of the last frame produces frame_done and rotates the spectrum buffer.
module spectrum_integration_ctrl #(
   parameter int FFT_LOG2     = 12,
   parameter int NINT_W       = 10,
   parameter int CPWR_LATENCY = 6,
   parameter int NBUF_LOG2    = 4
) (
   input logic                        clk,
   input logic                        rst_n,
   spectrum_integration_ctrl_if.slave bus
);

   localparam logic [FFT_LOG2-1:0] LAST_BIN  = {FFT_LOG2{1'b1}};
   localparam logic [FFT_LOG2-1:0] BIN_ZERO  = {FFT_LOG2{1'b0}};
   localparam logic [NINT_W-1:0]   NINT_ZERO = {NINT_W{1'b0}};
   localparam logic [NINT_W-1:0]   NINT_ONE  = {{(NINT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_INTEG = 2'd2
   } state_t;

   state_t                 state_r;
   logic [FFT_LOG2-1:0]    bin_r;
   logic [NINT_W-1:0]      int_cnt_r;
   logic [NINT_W-1:0]      nint_l_r;
   logic                   peak_l_r;
   logic                   acc_clken_r;
   logic                   acc_add_r;
   logic                   acc_peak_r;
   logic [FFT_LOG2-1:0]    rd_addr_r;
   logic                   marker_r;
   logic                   misalign_r;
   logic [CPWR_LATENCY-1:0] dly_vld_r;
   logic [CPWR_LATENCY-1:0] dly_mrk_r;
   logic [FFT_LOG2-1:0]    dly_addr_r [CPWR_LATENCY];
   logic [NBUF_LOG2-1:0]   buf_idx_r;

   logic [NINT_W-1:0]      nint_eff_s;
   logic [NINT_W-1:0]      nint_cur_s;
   logic                   start_s;
   logic                   peak_cur_s;
   logic                   bin_last_s;
   logic                   misalign_s;
   logic                   int_final_s;

   // Decode integration start/end and the in_last versus bin-counter check.
   always_comb begin
      start_s    = (bin_r == BIN_ZERO) && (int_cnt_r == NINT_ZERO);
      bin_last_s = (bin_r == LAST_BIN);
      misalign_s = (bus.in_last != bin_last_s);
      if (bus.num_integrations == NINT_ZERO) begin
         nint_eff_s = NINT_ONE;
      end else begin
         nint_eff_s = bus.num_integrations;
      end
      // At the first sample of an integration the live config applies,
      // afterwards the values latched at that sample are used.
      if (start_s) begin
         nint_cur_s = nint_eff_s;
         peak_cur_s = bus.peak_detect_cfg;
      end else begin
         nint_cur_s = nint_l_r;
         peak_cur_s = peak_l_r;
      end
      int_final_s = (int_cnt_r == (nint_cur_s - NINT_ONE));
   end

   // Control FSM: bin/integration counters and registered accumulator controls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         bin_r       <= BIN_ZERO;
         int_cnt_r   <= NINT_ZERO;
         nint_l_r    <= NINT_ONE;
         peak_l_r    <= 1'b0;
         acc_clken_r <= 1'b0;
         acc_add_r   <= 1'b0;
         acc_peak_r  <= 1'b0;
         rd_addr_r   <= BIN_ZERO;
         marker_r    <= 1'b0;
         misalign_r  <= 1'b0;
      end else begin
         acc_clken_r <= 1'b0;
         marker_r    <= 1'b0;
         misalign_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.enable) begin
                  state_r <= ST_SYNC;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SYNC: begin
               if (!bus.enable) begin
                  state_r <= ST_IDLE;
               end else if (bus.in_valid && bus.in_last) begin
                  state_r   <= ST_INTEG;
                  bin_r     <= BIN_ZERO;
                  int_cnt_r <= NINT_ZERO;
               end else begin
                  state_r <= ST_SYNC;
               end
            end
            ST_INTEG: begin
               if (!bus.enable) begin
                  state_r <= ST_IDLE;
               end else if (bus.in_valid) begin
                  if (misalign_s) begin
                     // Drop the partial integration; pending writes still drain.
                     misalign_r <= 1'b1;
                     state_r    <= ST_SYNC;
                  end else begin
                     acc_clken_r <= 1'b1;
                     rd_addr_r   <= bin_r;
                     acc_add_r   <= (int_cnt_r != NINT_ZERO);
                     acc_peak_r  <= peak_cur_s;
                     if (start_s) begin
                        nint_l_r <= nint_eff_s;
                        peak_l_r <= bus.peak_detect_cfg;
                     end
                     if (bin_last_s) begin
                        bin_r <= BIN_ZERO;
                        if (int_final_s) begin
                           int_cnt_r <= NINT_ZERO;
                           marker_r  <= 1'b1;
                        end else begin
                           int_cnt_r <= int_cnt_r + NINT_ONE;
                        end
                     end else begin
                        bin_r <= bin_r + {{(FFT_LOG2-1){1'b0}}, 1'b1};
                     end
                  end
               end else begin
                  state_r <= ST_INTEG;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Write-back delay line: matches the accumulator latency, never flushed on abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_vld_r <= {CPWR_LATENCY{1'b0}};
         dly_mrk_r <= {CPWR_LATENCY{1'b0}};
         for (int i = 0; i < CPWR_LATENCY; i++) begin
            dly_addr_r[i] <= BIN_ZERO;
         end
      end else begin
         dly_vld_r[0]  <= acc_clken_r;
         dly_mrk_r[0]  <= marker_r;
         dly_addr_r[0] <= rd_addr_r;
         for (int i = 1; i < CPWR_LATENCY; i++) begin
            dly_vld_r[i]  <= dly_vld_r[i-1];
            dly_mrk_r[i]  <= dly_mrk_r[i-1];
            dly_addr_r[i] <= dly_addr_r[i-1];
         end
      end
   end

   // Rotate the spectrum buffer the cycle after a completed spectrum's final write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_idx_r <= {NBUF_LOG2{1'b0}};
      end else if (dly_mrk_r[CPWR_LATENCY-1]) begin
         buf_idx_r <= buf_idx_r + {{(NBUF_LOG2-1){1'b0}}, 1'b1};
      end else begin
         buf_idx_r <= buf_idx_r;
      end
   end

   assign bus.acc_clken    = acc_clken_r;
   assign bus.acc_add      = acc_add_r;
   assign bus.acc_peak     = acc_peak_r;
   assign bus.rd_addr      = rd_addr_r;
   assign bus.wr_en        = dly_vld_r[CPWR_LATENCY-1];
   assign bus.wr_addr      = dly_addr_r[CPWR_LATENCY-1];
   assign bus.frame_done   = dly_mrk_r[CPWR_LATENCY-1];
   assign bus.buf_idx      = buf_idx_r;
   assign bus.misalign_err = misalign_r;

endmodule

// File: tb/tb_spectrum_integration_ctrl.sv
// Self-checking bench for spectrum_integration_ctrl (8 bins, latency 6,
// 4 buffers). A behavioural model tracks sync/frame position and schedules
// expected write-backs in a queue; every cycle all outputs are compared.
module tb_spectrum_integration_ctrl;
   localparam int FFT_LOG2  = 3;
   localparam int NINT_W    = 10;
   localparam int LAT       = 6;
   localparam int NBUF_LOG2 = 2;
   localparam int NB        = 8;
   localparam int NBUFS     = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   spectrum_integration_ctrl_if #(
      .FFT_LOG2(FFT_LOG2), .NINT_W(NINT_W), .NBUF_LOG2(NBUF_LOG2)
   ) bus ();

   spectrum_integration_ctrl #(
      .FFT_LOG2(FFT_LOG2), .NINT_W(NINT_W), .CPWR_LATENCY(LAT), .NBUF_LOG2(NBUF_LOG2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int addr;
      bit fin;
   } wr_t;

   wr_t wq[$];
   int  passed = 0;
   int  fails  = 0;
   int  total  = 0;
   int  edge_n = 0;
   // model: mode 0 = stopped, 1 = waiting for frame end, 2 = integrating
   int  m_mode = 0;
   int  m_pos  = 0;
   int  m_frm  = 0;
   int  m_n    = 1;
   bit  m_pk   = 1'b0;
   int  exp_buf = 0;
   bit  bump   = 1'b0;
   bit  e_clken, e_mis, e_add, e_pk;
   int  e_rd;
   int  fd_cnt, mis_cnt, wr_cnt, clken_cnt;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_step();
      bit fin;
      e_clken = 1'b0;
      e_mis   = 1'b0;
      case (m_mode)
         0: begin
            if (bus.enable) m_mode = 1;
         end
         1: begin
            if (!bus.enable) m_mode = 0;
            else if (bus.in_valid && bus.in_last) begin
               m_mode = 2; m_pos = 0; m_frm = 0;
            end
         end
         2: begin
            if (!bus.enable) m_mode = 0;
            else if (bus.in_valid) begin
               if (bus.in_last != (m_pos == NB-1)) begin
                  e_mis = 1'b1; m_mode = 1;
               end else begin
                  if (m_pos == 0 && m_frm == 0) begin
                     m_n  = (bus.num_integrations == 0) ? 1 : int'(bus.num_integrations);
                     m_pk = bus.peak_detect_cfg;
                  end
                  e_clken = 1'b1;
                  e_rd    = m_pos;
                  e_add   = (m_frm != 0);
                  e_pk    = m_pk;
                  fin     = (m_pos == NB-1) && (m_frm == m_n-1);
                  wq.push_back('{due: edge_n + 1 + LAT, addr: m_pos, fin: fin});
                  if (m_pos == NB-1) begin
                     m_pos = 0;
                     m_frm = (m_frm + 1) % m_n;
                  end else begin
                     m_pos++;
                  end
               end
            end
         end
         default: m_mode = 0;
      endcase
   endtask

   task automatic tick();
      bit ew;
      model_step();
      @(posedge clk);
      edge_n++;
      #1;
      if (bus.frame_done === 1'b1)   fd_cnt++;
      if (bus.misalign_err === 1'b1) mis_cnt++;
      if (bus.wr_en === 1'b1)        wr_cnt++;
      if (bus.acc_clken === 1'b1)    clken_cnt++;
      chk("acc_clken", 32'(bus.acc_clken), 32'(e_clken));
      if (e_clken) begin
         chk("rd_addr",  32'(bus.rd_addr),  32'(e_rd));
         chk("acc_add",  32'(bus.acc_add),  32'(e_add));
         chk("acc_peak", 32'(bus.acc_peak), 32'(e_pk));
      end
      chk("misalign_err", 32'(bus.misalign_err), 32'(e_mis));
      if (bump) exp_buf = (exp_buf + 1) % NBUFS;
      chk("buf_idx", 32'(bus.buf_idx), 32'(exp_buf));
      ew = (wq.size() > 0) && (wq[0].due == edge_n);
      chk("wr_en", 32'(bus.wr_en), 32'(ew));
      if (ew) begin
         chk("wr_addr",    32'(bus.wr_addr),    32'(wq[0].addr));
         chk("frame_done", 32'(bus.frame_done), 32'(wq[0].fin));
         bump = wq[0].fin;
         void'(wq.pop_front());
      end else begin
         chk("frame_done", 32'(bus.frame_done), 32'd0);
         bump = 1'b0;
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b0;
         bus.in_last  = 1'($urandom_range(0, 1));
         tick();
      end
   endtask

   // gap: 0 = back-to-back, 1 = one stall before every sample, 2 = random stalls
   task automatic send_frame(int nb, int gap);
      for (int b = 0; b < nb; b++) begin
         if (gap == 1) idle(1);
         else if (gap == 2) idle($urandom_range(0, 2));
         bus.in_valid = 1'b1;
         bus.in_last  = (b == nb - 1);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_acc_clken",    32'(bus.acc_clken),    32'd0);
      chk("rst_acc_add",      32'(bus.acc_add),      32'd0);
      chk("rst_acc_peak",     32'(bus.acc_peak),     32'd0);
      chk("rst_rd_addr",      32'(bus.rd_addr),      32'd0);
      chk("rst_wr_en",        32'(bus.wr_en),        32'd0);
      chk("rst_wr_addr",      32'(bus.wr_addr),      32'd0);
      chk("rst_buf_idx",      32'(bus.buf_idx),      32'd0);
      chk("rst_frame_done",   32'(bus.frame_done),   32'd0);
      chk("rst_misalign_err", 32'(bus.misalign_err), 32'd0);
      @(posedge clk);
      edge_n++;
      #1;
      rst_n = 1'b1;
      wq.delete();
      m_mode = 0; m_pos = 0; m_frm = 0; m_n = 1; m_pk = 1'b0;
      exp_buf = 0; bump = 1'b0;
   endtask

   task automatic scen_begin();
      fd_cnt = 0; mis_cnt = 0; wr_cnt = 0; clken_cnt = 0;
   endtask

   initial begin
      bus.enable           = 1'b0;
      bus.num_integrations = 10'd0;
      bus.peak_detect_cfg  = 1'b0;
      bus.in_valid         = 1'b0;
      bus.in_last          = 1'b0;
      #2;
      do_reset();

      // 1: partial frame discarded in SYNC, then one 3-frame spectrum
      scen_begin();
      bus.enable           = 1'b1;
      bus.num_integrations = 10'd3;
      bus.peak_detect_cfg  = 1'($urandom_range(0, 1));
      tick();
      send_frame(3, 0);
      repeat (3) send_frame(NB, 0);
      idle(LAT + 3);
      chk("s1_frame_done_count", 32'(fd_cnt), 32'd1);
      chk("s1_write_count",      32'(wr_cnt), 32'd24);
      chk("s1_buf_idx",          32'(bus.buf_idx), 32'd1);

      // 2: nint=0 acts as 1, buffer index wraps
      scen_begin();
      bus.num_integrations = 10'd0;
      repeat (4) send_frame(NB, 0);
      idle(LAT + 3);
      chk("s2_frame_done_count", 32'(fd_cnt), 32'd4);
      chk("s2_buf_idx",          32'(bus.buf_idx), 32'd1);

      // 3: early in_last, then missing in_last at the last bin
      scen_begin();
      bus.num_integrations = 10'd3;
      send_frame(NB, 0);
      send_frame(6, 0);
      send_frame(NB, 0);
      repeat (3) send_frame(NB, 0);
      send_frame(9, 0);
      idle(LAT + 3);
      chk("s3_misalign_count",   32'(mis_cnt), 32'd2);
      chk("s3_frame_done_count", 32'(fd_cnt),  32'd1);

      // 4: stalls every other cycle, config change mid-integration ignored
      scen_begin();
      bus.num_integrations = 10'd3;
      send_frame(NB, 1);
      bus.num_integrations = 10'd1;
      bus.peak_detect_cfg  = ~bus.peak_detect_cfg;
      send_frame(NB, 1);
      send_frame(NB, 1);
      bus.num_integrations = 10'd3;
      idle(LAT + 3);
      chk("s4_frame_done_count", 32'(fd_cnt), 32'd1);
      chk("s4_write_count",      32'(wr_cnt), 32'd24);

      // 5: disable right after the final bin, writes drain, then restart via SYNC
      scen_begin();
      bus.num_integrations = 10'd1;
      send_frame(NB, 0);
      bus.enable = 1'b0;
      idle(LAT + 3);
      chk("s5_frame_done_count", 32'(fd_cnt), 32'd1);
      send_frame(NB, 0);
      bus.enable = 1'b1;
      tick();
      send_frame(NB, 0);
      chk("s5_clken_count", 32'(clken_cnt), 32'd8);

      // 6: async reset mid-frame, no writes until resynchronised
      send_frame(4, 0);
      do_reset();
      scen_begin();
      tick();
      send_frame(4, 0);
      idle(LAT + 3);
      chk("s6_writes_before_resync", 32'(wr_cnt), 32'd0);
      bus.num_integrations = 10'd1;
      send_frame(NB, 0);
      idle(LAT + 3);
      chk("s6_frame_done_count", 32'(fd_cnt), 32'd1);

      // random traffic: config, frame lengths, stalls and enable drops
      scen_begin();
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 2) == 0) bus.num_integrations = 10'($urandom_range(0, 3));
         bus.peak_detect_cfg = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) begin
            bus.enable = 1'b0;
            idle($urandom_range(1, 3));
            bus.enable = 1'b1;
         end
         if ($urandom_range(0, 5) == 0) send_frame($urandom_range(1, 10), $urandom_range(0, 2));
         else send_frame(NB, $urandom_range(0, 2));
      end
      idle(LAT + 3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
